// File: rtl/round_pkg.sv
// Shared encodings, widths and state type for the round judge.
package round_pkg;

  localparam logic [2:0] LV1 = 3'b001;
  localparam logic [2:0] LV2 = 3'b010;
  localparam logic [2:0] LV3 = 3'b100;

  localparam int SLOT_W    = 3;
  localparam int MAX_SLOTS = 16;
  localparam int BUS_W     = SLOT_W * MAX_SLOTS;

  localparam logic [4:0] NO_MISS = 5'h1F;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    REPORT,
    GAME_OVER
  } state_t;

  // Slot count for a one-hot level; 0 marks an invalid level.
  function automatic logic [4:0] lv_to_slots(input logic [2:0] lv);
    case (lv)
      LV1:     return 5'd8;
      LV2:     return 5'd12;
      LV3:     return 5'd16;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/slot_select.sv
// Picks one 3-bit slot out of a packed 16-slot bus.
// Purely combinational, no flow control.
module slot_select
  import round_pkg::*;
(
  input  logic [BUS_W-1:0]  bus,
  input  logic [3:0]        idx,
  output logic [SLOT_W-1:0] slot
);

  logic [SLOT_W-1:0] slots [MAX_SLOTS];

  for (genvar k = 0; k < MAX_SLOTS; k++) begin : g_unpack
    assign slots[k] = bus[k*SLOT_W +: SLOT_W];
  end

  assign slot = slots[idx];

endmodule

// File: rtl/round_judge.sv
// Judges an answer round slot-by-slot against the pattern and keeps the game tallies.
// Verdict N+1 cycles after the enable edge; no backpressure, each round needs a fresh enable edge.
module round_judge
  import round_pkg::*;
#(
  parameter int NUM_ROUNDS  = 10,
  parameter int PTS_PER_WIN = 10
) (
  input  logic             clk_1,
  input  logic             rst,
  input  logic             enable,
  input  logic [2:0]       level,
  input  logic [BUS_W-1:0] pattern_bus,
  input  logic [BUS_W-1:0] answer_bus,
  output logic             busy,
  output logic             done,
  output logic             round_win,
  output logic [4:0]       match_count,
  output logic [4:0]       first_miss,
  output logic [4:0]       round_count,
  output logic [3:0]       answer_count,
  output logic [6:0]       score,
  output logic             next_round,
  output logic             game_end,
  output logic             level_err
);

  state_t state, state_nxt;

  logic              enable_q;
  logic              start;
  logic [4:0]        lv_slots;
  logic [4:0]        n_slots;
  logic [3:0]        idx;
  logic [4:0]        match_run;
  logic              miss_seen;
  logic [4:0]        miss_idx;
  logic [SLOT_W-1:0] pat_slot;
  logic [SLOT_W-1:0] ans_slot;
  logic              hit;
  logic              last_slot;
  logic [4:0]        final_match;
  logic [4:0]        final_miss;
  logic              win;
  logic [4:0]        rc_next;
  logic [3:0]        ac_next;

  slot_select u_pat (.bus(pattern_bus), .idx(idx), .slot(pat_slot));
  slot_select u_ans (.bus(answer_bus),  .idx(idx), .slot(ans_slot));

  assign start     = enable & ~enable_q;
  assign lv_slots  = lv_to_slots(level);
  assign hit       = (pat_slot == ans_slot);
  assign last_slot = ({1'b0, idx} == n_slots - 5'd1);
  assign busy      = (state == COMPARE) || (state == REPORT);

  // Verdict includes the slot being compared in the final COMPARE cycle.
  always_comb begin
    final_match = match_run + {4'd0, hit};
    final_miss  = (miss_seen || hit) ? miss_idx : {1'b0, idx};
    win         = (final_match == n_slots);
    rc_next     = round_count + 5'd1;
    ac_next     = answer_count + {3'd0, win};
  end

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start && lv_slots != 5'd0) state_nxt = COMPARE;
      COMPARE:   if (last_slot) state_nxt = REPORT;
      REPORT:    state_nxt = game_end ? GAME_OVER : IDLE;
      GAME_OVER: state_nxt = GAME_OVER;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      enable_q     <= 1'b0;
      n_slots      <= 5'd0;
      idx          <= 4'd0;
      match_run    <= 5'd0;
      miss_seen    <= 1'b0;
      miss_idx     <= NO_MISS;
      done         <= 1'b0;
      round_win    <= 1'b0;
      match_count  <= 5'd0;
      first_miss   <= NO_MISS;
      round_count  <= 5'd0;
      answer_count <= 4'd0;
      score        <= 7'd0;
      next_round   <= 1'b0;
      game_end     <= 1'b0;
      level_err    <= 1'b0;
    end else begin
      enable_q   <= enable;
      done       <= 1'b0;
      next_round <= 1'b0;
      level_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (lv_slots == 5'd0) begin
              level_err <= 1'b1;
            end else begin
              n_slots   <= lv_slots;
              idx       <= 4'd0;
              match_run <= 5'd0;
              miss_seen <= 1'b0;
              miss_idx  <= NO_MISS;
            end
          end
        end
        COMPARE: begin
          idx       <= idx + 4'd1;
          match_run <= final_match;
          if (!hit && !miss_seen) begin
            miss_seen <= 1'b1;
            miss_idx  <= {1'b0, idx};
          end
          // Results land as REPORT begins so they are valid alongside done.
          if (last_slot) begin
            match_count  <= final_match;
            first_miss   <= final_miss;
            round_win    <= win;
            round_count  <= rc_next;
            answer_count <= ac_next;
            score        <= 7'(ac_next * PTS_PER_WIN);
            done         <= 1'b1;
            if (rc_next == 5'(NUM_ROUNDS)) game_end   <= 1'b1;
            else                           next_round <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_round_judge.sv
// Randomized scenario bench for round_judge against a slot-counting game model.
module tb_round_judge;

  localparam int NUM_ROUNDS = 10;
  localparam int PTS        = 10;

  logic        clk_1 = 1'b0;
  logic        rst;
  logic        enable;
  logic [2:0]  level;
  logic [47:0] pattern_bus;
  logic [47:0] answer_bus;
  logic        busy, done, round_win, next_round, game_end, level_err;
  logic [4:0]  match_count, first_miss, round_count;
  logic [3:0]  answer_count;
  logic [6:0]  score;

  round_judge #(.NUM_ROUNDS(NUM_ROUNDS), .PTS_PER_WIN(PTS)) dut (
    .clk_1(clk_1), .rst(rst), .enable(enable), .level(level),
    .pattern_bus(pattern_bus), .answer_bus(answer_bus),
    .busy(busy), .done(done), .round_win(round_win), .match_count(match_count),
    .first_miss(first_miss), .round_count(round_count), .answer_count(answer_count),
    .score(score), .next_round(next_round), .game_end(game_end), .level_err(level_err)
  );

  always #5 clk_1 = ~clk_1;

  typedef struct packed {
    logic [7:0] latency;
    logic [7:0] busy_cnt;
    logic [3:0] done_cnt;
    logic [3:0] next_cnt;
    logic [3:0] lerr_cnt;
    logic       nad;
    logic       win;
    logic [4:0] mc;
    logic [4:0] fm;
    logic [4:0] rc;
    logic [3:0] ac;
    logic [6:0] sc;
    logic       ge;
  } obs_t;

  int n_checks = 0;
  int n_pass   = 0;

  int m_rounds, m_wins, m_mc, m_fm;
  bit m_win, m_over;

  function automatic int lv_n(input logic [2:0] lv);
    case (lv)
      3'b001:  return 8;
      3'b010:  return 12;
      3'b100:  return 16;
      default: return 0;
    endcase
  endfunction

  function automatic logic [47:0] rand_bus();
    return 48'({$urandom(), $urandom()});
  endfunction

  function automatic logic [2:0] rand_level();
    case ($urandom_range(0, 2))
      0:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic model_reset();
    m_rounds = 0; m_wins = 0; m_mc = 0; m_fm = 31; m_win = 0; m_over = 0;
  endtask

  // Game rules: count equal slots among the first N, note the first unequal one.
  task automatic predict(input logic [2:0] lv, input logic [47:0] pat, input logic [47:0] ans,
                         output obs_t e);
    int n, hits, fm;
    n = lv_n(lv);
    e = '0;
    if (!m_over && n == 0) begin
      e.lerr_cnt = 4'd1;
    end else if (!m_over) begin
      hits = 0; fm = 31;
      for (int k = 0; k < n; k++) begin
        if (pat[3*k +: 3] == ans[3*k +: 3]) hits++;
        else if (fm == 31) fm = k;
      end
      m_rounds++;
      m_win = (hits == n);
      if (m_win) m_wins++;
      m_mc = hits; m_fm = fm;
      m_over = (m_rounds == NUM_ROUNDS);
      e.latency  = 8'(n + 1);
      e.busy_cnt = 8'(n + 1);
      e.done_cnt = 4'd1;
      e.next_cnt = m_over ? 4'd0 : 4'd1;
      e.nad      = !m_over;
    end
    e.win = m_win;
    e.mc  = 5'(m_mc);
    e.fm  = 5'(m_fm);
    e.rc  = 5'(m_rounds);
    e.ac  = 4'(m_wins);
    e.sc  = 7'(m_wins * PTS);
    e.ge  = m_over;
  endtask

  task automatic snap(inout obs_t o);
    o.nad = next_round; o.win = round_win; o.mc = match_count; o.fm = first_miss;
    o.rc = round_count; o.ac = answer_count; o.sc = score; o.ge = game_end;
  endtask

  // Raise enable and hold it for the window, recording what the DUT does.
  task automatic run_round(input logic [2:0] lv, input logic [47:0] pat, input logic [47:0] ans,
                           input int hold, output obs_t o);
    o = '0;
    @(negedge clk_1);
    level = lv; pattern_bus = pat; answer_bus = ans; enable = 1'b1;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk_1);
      if (busy)       o.busy_cnt = o.busy_cnt + 8'd1;
      if (next_round) o.next_cnt = o.next_cnt + 4'd1;
      if (level_err)  o.lerr_cnt = o.lerr_cnt + 4'd1;
      if (done) begin
        o.done_cnt = o.done_cnt + 4'd1;
        if (o.latency == 8'd0) begin
          o.latency = 8'(k);
          snap(o);
        end
      end
    end
    if (o.latency == 8'd0) snap(o);
    enable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] act, req;
    req = {3'b000, 5'd0, 5'h1F, 5'd0, 4'd0, 7'd0, 3'b000};
    act = {busy, done, round_win, match_count, first_miss, round_count, answer_count,
           score, next_round, game_end, level_err};
    n_checks++;
    if (act !== req) $display("FAIL reset_outputs got %h want %h", act, req);
    else n_pass++;
    @(negedge clk_1); rst = 1'b1;
    @(negedge clk_1);
    act = {busy, done, round_win, match_count, first_miss, round_count, answer_count,
           score, next_round, game_end, level_err};
    n_checks++;
    if (act !== req) $display("FAIL after_reset_idle got %h want %h", act, req);
    else n_pass++;
  endtask

  task automatic test_full_match();
    obs_t o, e;
    logic [47:0] p;
    p = rand_bus();
    predict(3'b001, p, p, e);
    run_round(3'b001, p, p, 24, o);
    n_checks++;
    if (o !== e) $display("FAIL full_match got %h want %h", o, e);
    else n_pass++;
    n_checks++;
    if ({o.latency, o.busy_cnt, o.mc, o.fm, o.rc, o.ac, o.sc, o.nad} !==
        {8'd9, 8'd9, 5'd8, 5'h1F, 5'd1, 4'd1, 7'd10, 1'b1})
      $display("FAIL full_match_plan got lat=%0d busy=%0d mc=%0d fm=%h rc=%0d ac=%0d sc=%0d nr=%0d",
               o.latency, o.busy_cnt, o.mc, o.fm, o.rc, o.ac, o.sc, o.nad);
    else n_pass++;
  endtask

  task automatic test_mismatch_l3();
    obs_t o, e;
    logic [47:0] p, a;
    p = rand_bus(); a = p;
    a[15 +: 3] = a[15 +: 3] ^ 3'b101;
    a[33 +: 3] = a[33 +: 3] ^ 3'b010;
    predict(3'b100, p, a, e);
    run_round(3'b100, p, a, 24, o);
    n_checks++;
    if (o !== e) $display("FAIL mismatch_l3 got %h want %h", o, e);
    else n_pass++;
    n_checks++;
    if ({o.latency, o.win, o.mc, o.fm, o.ac, o.nad} !== {8'd17, 1'b0, 5'd14, 5'd5, 4'd1, 1'b1})
      $display("FAIL mismatch_l3_plan got lat=%0d win=%0d mc=%0d fm=%0d ac=%0d nr=%0d",
               o.latency, o.win, o.mc, o.fm, o.ac, o.nad);
    else n_pass++;
  endtask

  task automatic test_beyond_n();
    obs_t o, e;
    logic [47:0] p, a;
    p = rand_bus(); a = p;
    a[39 +: 3] = a[39 +: 3] ^ 3'b111;
    a[45 +: 3] = a[45 +: 3] ^ 3'b001;
    predict(3'b010, p, a, e);
    run_round(3'b010, p, a, 24, o);
    n_checks++;
    if (o !== e) $display("FAIL beyond_n got %h want %h", o, e);
    else n_pass++;
    n_checks++;
    if ({o.win, o.mc, o.fm} !== {1'b1, 5'd12, 5'h1F})
      $display("FAIL beyond_n_plan got win=%0d mc=%0d fm=%h", o.win, o.mc, o.fm);
    else n_pass++;
  endtask

  task automatic test_level_err();
    obs_t o, e;
    logic [47:0] p;
    logic [2:0] bad [4];
    bad[0] = 3'b011; bad[1] = 3'b000; bad[2] = 3'b111; bad[3] = 3'b110;
    p = rand_bus();
    for (int i = 0; i < 2; i++) begin
      logic [2:0] lv;
      lv = (i == 0) ? 3'b011 : bad[$urandom_range(1, 3)];
      predict(lv, p, p, e);
      run_round(lv, p, p, 20, o);
      n_checks++;
      if (o !== e) $display("FAIL level_err lv=%b got %h want %h", lv, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_hold_enable();
    obs_t o, e;
    logic [47:0] p;
    logic [2:0] lv;
    p = rand_bus(); lv = rand_level();
    predict(lv, p, p, e);
    run_round(lv, p, p, 50, o);
    n_checks++;
    if (o !== e) $display("FAIL hold_enable got %h want %h", o, e);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    logic [47:0] p;
    logic [31:0] act, req;
    int seen;
    p = rand_bus();
    @(negedge clk_1);
    level = 3'b001; pattern_bus = p; answer_bus = p; enable = 1'b1;
    repeat (4) @(negedge clk_1);
    rst = 1'b0;
    #1;
    req = {3'b000, 5'd0, 5'h1F, 5'd0, 4'd0, 7'd0, 3'b000};
    act = {busy, done, round_win, match_count, first_miss, round_count, answer_count,
           score, next_round, game_end, level_err};
    n_checks++;
    if (act !== req) $display("FAIL reset_mid_clear got %h want %h", act, req);
    else n_pass++;
    enable = 1'b0; seen = 0;
    repeat (6) begin
      @(negedge clk_1);
      if (done || busy || next_round) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL reset_mid_quiet got %0d active cycles want 0", seen);
    else n_pass++;
    rst = 1'b1;
    model_reset();
    p = rand_bus();
    predict(3'b100, p, p, e);
    run_round(3'b100, p, p, 24, o);
    n_checks++;
    if (o !== e || o.rc !== 5'd1) $display("FAIL reset_mid_rejudge got %h want %h", o, e);
    else n_pass++;
  endtask

  task automatic test_game();
    obs_t o, e;
    logic [47:0] p, a;
    logic [2:0] lv;
    bit sched [NUM_ROUNDS];
    int n, j;
    @(negedge clk_1); rst = 1'b0;
    @(negedge clk_1); rst = 1'b1;
    model_reset();
    for (int i = 0; i < NUM_ROUNDS; i++) sched[i] = (i < 7);
    for (int i = NUM_ROUNDS - 1; i > 0; i--) begin
      bit t;
      j = $urandom_range(0, i);
      t = sched[i]; sched[i] = sched[j]; sched[j] = t;
    end
    for (int r = 0; r < NUM_ROUNDS; r++) begin
      lv = rand_level(); n = lv_n(lv);
      p = rand_bus(); a = p;
      for (int k = n; k < 16; k++) a[3*k +: 3] = 3'($urandom());
      if (!sched[r]) begin
        j = $urandom_range(0, n - 1);
        a[3*j +: 3] = a[3*j +: 3] ^ 3'($urandom_range(1, 7));
        if ($urandom_range(0, 1) == 1) begin
          j = $urandom_range(0, n - 1);
          a[3*j +: 3] = 3'($urandom());
        end
      end
      predict(lv, p, a, e);
      run_round(lv, p, a, 24, o);
      n_checks++;
      if (o !== e) $display("FAIL game_round%0d got %h want %h", r + 1, o, e);
      else n_pass++;
    end
    n_checks++;
    if ({o.ge, o.sc, o.ac, o.rc, o.next_cnt} !== {1'b1, 7'd70, 4'd7, 5'd10, 4'd0})
      $display("FAIL game_final got ge=%0d sc=%0d ac=%0d rc=%0d nr=%0d",
               o.ge, o.sc, o.ac, o.rc, o.next_cnt);
    else n_pass++;
    p = rand_bus();
    predict(3'b001, p, p, e);
    run_round(3'b001, p, p, 30, o);
    n_checks++;
    if (o !== e) $display("FAIL game_over_valid_edge got %h want %h", o, e);
    else n_pass++;
    predict(3'b011, p, p, e);
    run_round(3'b011, p, p, 20, o);
    n_checks++;
    if (o !== e) $display("FAIL game_over_bad_level got %h want %h", o, e);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; level = 3'b000; pattern_bus = '0; answer_bus = '0;
    model_reset();
    repeat (3) @(negedge clk_1);
    test_reset();
    test_full_match();
    test_mismatch_l3();
    test_beyond_n();
    test_level_err();
    test_hold_enable();
    test_reset_mid();
    test_game();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/round_judge.md
Name: round_judge

Overview:
- Reads back the answer slots written by the input-trimming stage and checks them against the generated pattern slots.
- Compares one slot per clock for the active level, then reports a pass/fail verdict for the round.
- Keeps the round and answer tallies and the final score; asserts game end.
- Sits between the input-capture stage and the 7-seg score display, and requests the next round from the loop-reset logic.

Parameters:
- NUM_ROUNDS, 10, rounds per game; must be ≤12 so score fits 7 bits.
- PTS_PER_WIN, 10, score points per won round.

Ports:
- clk_1  in  1  system clock
- rst  in  1  asynchronous active-low reset
- enable  in  1  level signal, held high by the capture stage once the answer is complete; a rising edge starts a judgement
- level  in  3  one-hot level: 001=8 slots, 010=12 slots, 100=16 slots
- pattern_bus  in  48  generated pattern; slot k (0..15) at bits [3k+2:3k]
- answer_bus  in  48  trimmed user input; same packing
- busy  out  1  high in COMPARE and REPORT
- done  out  1  one-cycle pulse when the verdict is valid
- round_win  out  1  verdict of the last judged round
- match_count  out  5  matching slots in the last round (0..16)
- first_miss  out  5  index of the first mismatching slot; 5'h1F if none
- round_count  out  5  rounds judged since reset
- answer_count  out  4  rounds won since reset
- score  out  7  answer_count*PTS_PER_WIN, updated in REPORT
- next_round  out  1  one-cycle pulse requesting the next round (loop reset)
- game_end  out  1  sticky high once round_count == NUM_ROUNDS
- level_err  out  1  one-cycle pulse when a start edge arrives with a non-one-hot level

Behaviour:
- Reset (async, rst=0): all outputs 0 except first_miss=5'h1F; state IDLE; enable history register cleared.
- Start detection:
  - enable is registered each cycle; start = enable & ~enable_q.
  - Edges are ignored unless state is IDLE.
- States IDLE, COMPARE, REPORT, GAME_OVER.
- IDLE, on start:
  - level must be exactly one of 001/010/100; otherwise pulse level_err and stay in IDLE.
  - If valid: latch N (8/12/16), clear idx, running match, miss flag and first-miss; go to COMPARE.
- COMPARE:
  - Each cycle compare slot idx of pattern_bus against answer_bus (3-bit equality).
  - Match increments the running count.
  - The first mismatch records idx into the first-miss register; later mismatches do not overwrite it.
  - idx increments each cycle; after slot N-1 go to REPORT. COMPARE lasts exactly N cycles.
  - Level and buses are sampled live during COMPARE, but level is used only at start (N is latched). Buses must stay stable; this is the capture stage's responsibility.
- REPORT (1 cycle):
  - Registered outputs update: match_count, first_miss, round_win = (match == N).
  - round_count += 1; answer_count += round_win.
  - score = new answer_count*PTS_PER_WIN, computed as a 7-bit product, no saturation needed.
  - done = 1.
  - If new round_count == NUM_ROUNDS: game_end = 1, go to GAME_OVER, no next_round.
  - Otherwise next_round = 1 in the same cycle as done; go to IDLE.
- Latency: start edge at cycle t → COMPARE t+1..t+N → done/next_round at t+N+1.
- GAME_OVER: absorbing. All start edges are ignored, outputs hold, and no level_err is raised. Exit only via rst.
- enable held high across rounds produces no retrigger. The capture stage must drop and re-raise it.
- rst mid-COMPARE/REPORT: immediate clear; a partial round is never counted.
- Slots beyond N are never examined; their values are don't-care.

Decomposition:
- Shared package round_pkg:
  - level encodings LV1/LV2/LV3
  - SLOT_W=3, MAX_SLOTS=16, NO_MISS=5'h1F
  - state enum {IDLE, COMPARE, REPORT, GAME_OVER}
  - function lv_to_slots(level) returning 8/12/16, or 0 if invalid
- Sub-module slot_select: combinational 48→3 slot mux by 4-bit index; instantiated twice (pattern, answer).
- Edge detect and counters stay inline.

Test Plan:
- Level 001, answer_bus==pattern_bus, enable 0→1 → busy for 9 cycles, done at t+9; round_win=1, match_count=8, first_miss=1F, round_count=1, answer_count=1, score=10, next_round=1.
- Level 100, slots 5 and 11 differ → done at t+17; round_win=0, match_count=14, first_miss=5, answer_count unchanged, next_round=1.
- Level 010, slot 13 differs (beyond N=12) → round_win=1, match_count=12.
- Ten rounds (7 wins, 3 losses) → 10th done with game_end=1, score=70, no next_round; an 11th enable edge produces no response.
- Level 011 with an enable edge → level_err pulse, state stays IDLE, counters unchanged; enable held high 50 cycles → single judgement only.
- rst deasserted→asserted (0) at COMPARE cycle 4 → all outputs 0, first_miss=1F, no done; next edge judges cleanly, round_count=1.
